// File: rtl/truth_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// bin2gray is used only when TRUTH_SWEEP_GRAY_EN is defined.
package truth_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        DONE  = 2'b10
    } sweep_state_t;

    localparam int MAX_INPUTS = 8;

    // The counter must be able to represent HOLD_CYCLES itself.
    function automatic int hold_cnt_width(input int hold_cycles);
        return $clog2(hold_cycles + 1);
    endfunction

    function automatic logic [MAX_INPUTS-1:0] bin2gray(input logic [MAX_INPUTS-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold timer: up-counter that pulses tc on the last cycle of each hold
// and wraps to zero; clear forces it back to zero.
module sweep_hold_timer
    import truth_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = hold_cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count;

    assign tc = enable && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tc) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every operand combination to a gate, samples its result after each
// hold and builds the truth table. Define TRUTH_SWEEP_GRAY_EN for Gray order.
module truth_table_sweeper
    import truth_sweep_pkg::*;
#(
    parameter int N_INPUTS    = 2,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     result_in,
    output logic [N_INPUTS-1:0]      operands,
    output logic                     busy,
    output logic                     done,
    output logic [2**N_INPUTS-1:0]   truth_table
);

    sweep_state_t state, next_state;

    logic [N_INPUTS-1:0] step;
    logic [N_INPUTS-1:0] step_next;
    logic [N_INPUTS-1:0] operands_next;
    logic                hold_done;
    logic                last_step;
    logic                timer_clear;
    logic                timer_en;

    assign step_next = step + N_INPUTS'(1);
    assign last_step = (step == '1);

    // step counts combinations; operands is its (optionally Gray-coded) image.
`ifdef TRUTH_SWEEP_GRAY_EN
    assign operands_next = N_INPUTS'(bin2gray(MAX_INPUTS'(step_next)));
`else
    assign operands_next = step_next;
`endif

    sweep_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (hold_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        busy        = 1'b0;
        done        = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (start) begin
                    next_state = DRIVE;
                end
            end
            DRIVE: begin
                busy     = 1'b1;
                timer_en = 1'b1;
                if (hold_done && last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Table is indexed by the driven value, so Gray order yields the same table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step        <= '0;
            operands    <= '0;
            truth_table <= '0;
        end else if (state == IDLE && start) begin
            step        <= '0;
            operands    <= '0;
            truth_table <= '0;
        end else if (state == DRIVE && hold_done) begin
            truth_table[operands] <= result_in;
            if (!last_step) begin
                step     <= step_next;
                operands <= operands_next;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default 2-input/10-cycle instance
// plus a 3-input/1-cycle instance, with hand-computed truth tables.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start0, start1;
    logic [1:0] ops0;
    logic       busy0, done0, res0;
    logic [3:0] tt0;
    logic [2:0] ops1;
    logic       busy1, done1, res1;
    logic [7:0] tt1;

    int gateSel;
    int assertCount = 0;
    int failCount   = 0;

    logic [1:0] seq2 [4];
    logic [2:0] seq3 [8];

    // Gate under sweep: 0 = AND, 1 = OR, otherwise NAND.
    assign res0 = (gateSel == 0) ? (&ops0) : (gateSel == 1) ? (|ops0) : ~(&ops0);
    assign res1 = ^ops1;

    truth_table_sweeper #(.N_INPUTS(2), .HOLD_CYCLES(10)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .start       (start0),
        .result_in   (res0),
        .operands    (ops0),
        .busy        (busy0),
        .done        (done0),
        .truth_table (tt0)
    );

    truth_table_sweeper #(.N_INPUTS(3), .HOLD_CYCLES(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .start       (start1),
        .result_in   (res1),
        .operands    (ops1),
        .busy        (busy1),
        .done        (done1),
        .truth_table (tt1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s0, input logic s1);
        start0 = s0;
        start1 = s1;
    endtask

    // One full sweep on dut0 from IDLE; optionally pulses start mid-sweep.
    task automatic runDefaultSweep(input string tag, input logic [3:0] expTable,
                                   input bit midPulse);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, "_cleared"}, 32'(tt0), 32'h0);
        for (int k = 0; k < 40; k++) begin
            checkOutput({tag, "_busy"}, 32'(busy0), 32'h1);
            checkOutput({tag, "_ops"}, 32'(ops0), 32'(seq2[k / 10]));
            checkOutput({tag, "_done_early"}, 32'(done0), 32'h0);
            if (midPulse && k == 15) applyStimulus(1'b1, 1'b0);
            else applyStimulus(1'b0, 1'b0);
            @(negedge clk);
        end
        checkOutput({tag, "_done"}, 32'(done0), 32'h1);
        checkOutput({tag, "_busy_end"}, 32'(busy0), 32'h0);
        checkOutput({tag, "_table"}, 32'(tt0), 32'(expTable));
        checkOutput({tag, "_ops_last"}, 32'(ops0), 32'(seq2[3]));
        @(negedge clk);
        checkOutput({tag, "_done_once"}, 32'(done0), 32'h0);
        checkOutput({tag, "_table_hold"}, 32'(tt0), 32'(expTable));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int firstDone, secondDone, doneCount;
        bit seen;
`ifdef TRUTH_SWEEP_GRAY_EN
        seq2 = '{2'd0, 2'd1, 2'd3, 2'd2};
        seq3 = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
        seq2 = '{2'd0, 2'd1, 2'd2, 2'd3};
        seq3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
        gateSel = 0;
        reset   = 1'b1;
        applyStimulus(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_ops", 32'(ops0), 32'h0);
        checkOutput("rst_busy", 32'(busy0), 32'h0);
        checkOutput("rst_done", 32'(done0), 32'h0);
        checkOutput("rst_table", 32'(tt0), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] AND sweep");
        runDefaultSweep("and", 4'b1000, 1'b0);

        $display("[TB] OR sweep with start pulse during DRIVE, then resweep");
        gateSel = 1;
        runDefaultSweep("or1", 4'b1110, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("or_idle_hold", 32'(tt0), 32'he);
        runDefaultSweep("or2", 4'b1110, 1'b0);

        $display("[TB] start held high");
        gateSel    = 0;
        firstDone  = -1;
        secondDone = -1;
        doneCount  = 0;
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        for (int k = 1; k <= 84; k++) begin
            @(negedge clk);
            if (done0) begin
                if (doneCount == 0) firstDone = k;
                else if (doneCount == 1) secondDone = k;
                doneCount++;
            end
        end
        checkOutput("held_done_count", 32'(doneCount), 32'd2);
        checkOutput("held_first_done", 32'(firstDone), 32'd40);
        checkOutput("held_second_done", 32'(secondDone), 32'd82);
        applyStimulus(1'b0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        checkOutput("held_drain_done", 32'(seen), 32'h1);
        checkOutput("held_table", 32'(tt0), 32'h8);
        @(negedge clk);

        $display("[TB] asynchronous reset mid-sweep");
        gateSel = 2;
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        repeat (17) @(negedge clk);
        checkOutput("pre_rst_ops", 32'(ops0), 32'(seq2[1]));
        checkOutput("pre_rst_table", 32'(tt0), 32'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_ops", 32'(ops0), 32'h0);
        checkOutput("async_rst_busy", 32'(busy0), 32'h0);
        checkOutput("async_rst_table", 32'(tt0), 32'h0);
        checkOutput("async_rst_done", 32'(done0), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("post_rst_no_done", 32'(done0), 32'h0);
        end
        runDefaultSweep("nand", 4'b0111, 1'b0);

        $display("[TB] 3-input XOR, one-cycle hold");
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("xor_cleared", 32'(tt1), 32'h0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("xor_ops", 32'(ops1), 32'(seq3[k]));
            checkOutput("xor_busy", 32'(busy1), 32'h1);
            @(negedge clk);
        end
        checkOutput("xor_done", 32'(done1), 32'h1);
        checkOutput("xor_busy_end", 32'(busy1), 32'h0);
        checkOutput("xor_table", 32'(tt1), 32'h96);
        @(negedge clk);
        checkOutput("xor_done_once", 32'(done1), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Stimulus-and-capture stage wrapped around a small combinational gate block, e.g. a 2-input AND.
- Steps `operands` through every input combination, holding each for a fixed number of cycles.
- Samples the gate's 1-bit result at the end of each hold and assembles a full truth-table vector.
- Replaces hand-written per-combination delay sequences in benches and on-board demos.

Parameters:
- `N_INPUTS`, default 2: width of `operands`; legal range 1..8.
- `HOLD_CYCLES`, default 10: cycles each combination is held before sampling; legal minimum 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  sampled only in IDLE; high starts a sweep.
- `result_in`  in  1  combinational result of the gate under sweep.
- `operands`  out  `N_INPUTS`  current input combination driven to the gate.
- `busy`  out  1  high in DRIVE.
- `done`  out  1  one-cycle pulse when the truth table is complete.
- `truth_table`  out  `2**N_INPUTS`  bit i = `result_in` sampled while `operands` == i.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is asynchronous and active-high.
- Reset values: state IDLE, `operands`=0, hold counter=0, `busy`=0, `done`=0, `truth_table`=0.
- States:
  - IDLE: `start`=1 moves to DRIVE; `operands`<=0, counter<=0, `truth_table`<=0.
  - DRIVE: counter increments each cycle.
    - When counter==`HOLD_CYCLES`-1: `truth_table[operands]`<=`result_in` and counter<=0.
    - If `operands` is the last combination, go to DONE; otherwise advance `operands`.
  - DONE: `done`=1 for exactly this one cycle, then unconditionally IDLE.
- Latency: the first `done` cycle begins `2**N_INPUTS`*`HOLD_CYCLES` edges after the edge that sampled `start`. Default: 40.
- Holding and ignored inputs:
  - `start` is ignored in DRIVE and DONE; no restart, no queueing.
  - `truth_table` holds its value through IDLE until the next accepted `start` clears it.
  - `operands` holds its last combination in DONE and IDLE.
- Sampling: `result_in` is sampled on the edge that ends the hold, so it has `HOLD_CYCLES` cycles to settle.
- `HOLD_CYCLES`=1: a new combination every cycle; each sample is taken on the first edge after the change.
- Wrap-around: `operands` never wraps inside a sweep. The last combination is sampled, then the block goes to DONE.
- Reset mid-sweep: the block aborts immediately into reset values. A partial table is discarded and `done` never pulses.
- Counter width: `$clog2(HOLD_CYCLES+1)`.

Optional Feature:
- Macro: `TRUTH_SWEEP_GRAY_EN`.
- Defined: `operands` follows a reflected Gray sequence, so one bit changes per step; for N=2 the order is 00,01,11,10.
  - Capture is still `truth_table[operands]`, indexed by the actual driven value, so the final table is identical to the binary sweep.
  - Completion occurs after the `2**N_INPUTS`th combination.
- Undefined: binary increment, 0..`2**N_INPUTS`-1.

Decomposition:
- Package `truth_sweep_pkg`:
  - State typedef enum {IDLE, DRIVE, DONE} with fixed 2-bit encoding.
  - Localparam helpers for the counter width.
  - Binary-to-Gray function used when `TRUTH_SWEEP_GRAY_EN` is defined.
- One sub-module, `sweep_hold_timer`:
  - Loadable down- or up-counter with a terminal-count pulse.
  - Parameterised by `HOLD_CYCLES`; clear input driven by the FSM.

Test Plan:
- Defaults, `result_in` = AND of `operands`, `start` pulsed one cycle → `busy` high for 40 cycles; `operands` 0,1,2,3, each held 10 cycles; `done` pulse at edge 40; `truth_table`=4'b1000.
- Same run with `result_in` = OR → `truth_table`=4'b1110. A second `start` clears the table to 0 on the accept edge, then rebuilds 4'b1110.
- `start` held high continuously → one sweep per 42 cycles: 40 DRIVE, 1 DONE, 1 IDLE re-accept; pulses during DRIVE cause no restart.
- `reset` asserted asynchronously at cycle 17 of a sweep → outputs zero immediately, no `done`; a new `start` yields a full correct table.
- `HOLD_CYCLES`=1, `N_INPUTS`=3, `result_in` = XOR-reduce → `done` 8 edges after `start`; `truth_table`=8'b1001_0110.
- `TRUTH_SWEEP_GRAY_EN` defined, defaults, AND → `operands` sequence 00,01,11,10; `truth_table`=4'b1000, `done` at edge 40.
